// File: rtl/axis_sample_source.sv
// ---------------------------------------------------------------------------
// axis_sample_source
// Test-signal generator with an AXI-Stream master output. A programmable
// divider paces sample generation; each sample is a constant, a ramp, a square
// wave or zero. With SAMPLE_SOURCE_NOISE_EN defined, an LFSR noise term is
// added and the sum is saturated.
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   enable         run/stop request
//   rate_div       sample period minus one, in clk cycles
//   mode           00 constant, 01 ramp, 10 square, 11 noise-only
//   level          signed amplitude / constant value
//   noise_shift    arithmetic right shift applied to the noise term
//   m_axis_tdata   sample out
//   m_axis_tvalid  sample valid
//   m_axis_tready  downstream ready
//   sample_count   accepted transfers, wraps at 2^32
//   overrun        sticky: a tick found the previous sample still pending
//
// Macro: SAMPLE_SOURCE_NOISE_EN enables the LFSR noise term.
// ---------------------------------------------------------------------------
module axis_sample_source #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned SQ_HALF   = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [15:0]             rate_div,
   input  logic [1:0]              mode,
   input  logic signed [WIDTH-1:0] level,
   input  logic [3:0]              noise_shift,
   output logic [WIDTH-1:0]        m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [31:0]             sample_count,
   output logic                    overrun
);

   localparam int unsigned PH_W = (2 * SQ_HALF > 1) ? $clog2(2 * SQ_HALF) : 1;
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(SQ_HALF);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SQ_HALF - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                  state;
   logic [15:0]             div_cnt;
   logic [WIDTH-1:0]        ramp;
   logic [PH_W-1:0]         phase;
   logic                    tick;
   logic                    xfer;
   logic                    gen;
   logic signed [WIDTH-1:0] base;
   logic signed [WIDTH-1:0] sample;

   // Divider tick only while running or holding; a generated sample needs enable
   assign tick = (state != ST_IDLE) && (div_cnt == rate_div);
   assign xfer = m_axis_tvalid && m_axis_tready;
   assign gen  = tick && enable &&
                 ((state == ST_RUN) || ((state == ST_HOLD) && xfer));

   // Noise-free waveform value for the next generated sample
   always_comb begin
      base = '0;
      case (mode)
         2'b00:   base = level;
         2'b01:   base = ramp;
         2'b10:   base = (phase < PH_HALF) ? level : ('0 - level);
         default: base = '0;
      endcase
   end

`ifdef SAMPLE_SOURCE_NOISE_EN
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [15:0]             lfsr;
   logic [15:0]             lfsr_next;
   logic signed [WIDTH-1:0] noise_raw;
   logic signed [WIDTH-1:0] noise;
   logic signed [WIDTH:0]   sum;

   // Galois form of x^16+x^14+x^13+x^11+1
   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // Low WIDTH bits of the LFSR as signed; sign-extended when WIDTH exceeds 16
   if (WIDTH >= 16) begin : g_noise_wide
      assign noise_raw = WIDTH'($signed(lfsr));
   end else begin : g_noise_narrow
      assign noise_raw = lfsr[WIDTH-1:0];
   end

   assign noise = noise_raw >>> noise_shift;
   assign sum   = {base[WIDTH-1], base} + {noise[WIDTH-1], noise};

   // Saturate when the carry-out disagrees with the sign bit
   always_comb begin
      sample = sum[WIDTH-1:0];
      if (sum[WIDTH] != sum[WIDTH-1]) begin
         sample = sum[WIDTH] ? S_MIN : S_MAX;
      end
   end

   // LFSR advances once per generated sample
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else if (gen) begin
         lfsr <= lfsr_next;
      end
   end
`else
   logic unused_noise_c;

   assign unused_noise_c = ^noise_shift;
   assign sample         = base;
`endif

   // Control FSM, divider, generators and registered stream outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         div_cnt       <= '0;
         ramp          <= '0;
         phase         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         sample_count  <= '0;
         overrun       <= 1'b0;
      end else begin
         if (xfer) begin
            sample_count <= sample_count + 32'd1;
         end

         if (state == ST_IDLE) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
         end

         if (gen) begin
            m_axis_tdata <= sample;
            ramp         <= ramp + WIDTH'(1);
            phase        <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  m_axis_tvalid <= 1'b1;
                  state         <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (xfer) begin
                  // Back-to-back load keeps tvalid high and stays in HOLD
                  if (!gen) begin
                     m_axis_tvalid <= 1'b0;
                     state         <= enable ? ST_RUN : ST_IDLE;
                  end
               end else if (tick) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               m_axis_tvalid <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/axis_sample_source.md
AXIS_SAMPLE_SOURCE -- requirements
Module: axis_sample_source

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter SQ_HALF, default 8, square-wave half-period in generated samples.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port enable  input  1  run/stop request.
REQ-007 Port rate_div  input  16  sample period minus one, in clk cycles.
REQ-008 Port mode  input  2  waveform: 00 constant, 01 ramp, 10 square, 11 noise-only.
REQ-009 Port level  input  WIDTH  signed amplitude/constant value.
REQ-010 Port noise_shift  input  4  arithmetic right-shift applied to noise term.
REQ-011 Port m_axis_tdata  output  WIDTH  sample out, AXI-Stream master.
REQ-012 Port m_axis_tvalid  output  1  sample valid.
REQ-013 Port m_axis_tready  input  1  downstream ready (fir_wrapper s_axis_tready).
REQ-014 Port sample_count  output  32  count of accepted transfers, wraps at 2^32.
REQ-015 Port overrun  output  1  sticky: a tick found the previous sample still pending.

Function
REQ-016 States IDLE, RUN, HOLD; IDLE->RUN when enable=1; RUN->HOLD on tick; HOLD->RUN on tvalid&&tready with enable=1, HOLD->IDLE on tvalid&&tready with enable=0; RUN->IDLE when enable=0.
REQ-017 Divider counts 0..rate_div in RUN and HOLD, tick when count==rate_div, then wraps to 0; rate_div=0 ticks every cycle; counter forced to 0 in IDLE.
REQ-018 Tick in RUN at cycle N registers a new sample; tvalid=1 and tdata valid at cycle N+1 (latency 1).
REQ-019 tdata and tvalid held stable while tvalid=1 and tready=0; tvalid never drops without a transfer.
REQ-020 Tick in HOLD without same-cycle transfer: sample dropped, generators not advanced, overrun set to 1; cleared only by reset.
REQ-021 Tick in HOLD coinciding with transfer: new sample loaded, tvalid stays 1 (back-to-back), no overrun.
REQ-022 enable dropping in HOLD: pending sample still completes; no new sample generated.
REQ-023 Base: mode 00 = level; mode 01 = ramp register, +1 per generated sample, wraps mod 2^WIDTH; mode 10 = +level for SQ_HALF samples then -level for SQ_HALF samples, starting +level; mode 11 = 0.
REQ-024 Ramp and square phase advance only on generated samples, in every mode.
REQ-025 sample_count increments on each cycle with tvalid&&tready.

Reset
REQ-026 In reset: state IDLE, tvalid=0, tdata=0, sample_count=0, overrun=0, divider=0, ramp=0, square phase=+level start, LFSR=LFSR_SEED.
REQ-027 Reset mid-transfer discards the pending sample; first tvalid after reset follows REQ-017/018.

Configuration
REQ-028 Macro SAMPLE_SOURCE_NOISE_EN defined: 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1), advanced once per generated sample; noise = low WIDTH bits of LFSR as signed, arithmetic-shifted right by noise_shift; tdata = base+noise saturated to signed WIDTH range.
REQ-029 Macro undefined: no LFSR logic, noise term 0, tdata = base; mode 11 outputs 0.

Verification
REQ-030 reset=1 2 cycles, enable=1, mode=00, level=16'h0100, rate_div=3, tready=1 -> tvalid one cycle every 4 cycles, tdata=16'h0100, sample_count=5 after 5 transfers.
REQ-031 mode=01, rate_div=0, tready=1, level ignored -> tdata 0,1,2,3... one per cycle, tvalid continuously 1; ramp 16'hFFFF followed by 16'h0000.
REQ-032 mode=00, rate_div=2, tready=0 for 10 cycles -> tdata/tvalid stable, overrun=1 after 1st extra tick; tready=1 -> one transfer, overrun stays 1.
REQ-033 mode=10, level=100, SQ_HALF=8, tready=1 -> 8 samples of 100, 8 of -100, repeating.
REQ-034 enable=0 during HOLD with tready=0 for 3 cycles -> sample held, transfers when tready=1, then IDLE, no further tvalid.
REQ-035 With SAMPLE_SOURCE_NOISE_EN, mode=00, level=16'h7FF0, noise_shift=0 -> tdata never wraps negative (saturates 16'h7FFF); mode=11, noise_shift=15 -> tdata only 0 or -1.
